// File: rtl/btn_pkg.sv
// Shared constants, helpers and the per-channel event bundle for the button filter bank.
// The timing defaults assume a 100 MHz board clock with a 1 ms sample tick.
package btn_pkg;

    localparam int SAMPLE_DIV_1MS = 100000;
    localparam int STABLE_8MS     = 8;
    localparam int LONG_1S        = 1000;
    localparam int REPEAT_200MS   = 200;

    typedef struct packed {
        logic level;
        logic press;
        logic rel;
        logic long_press;
        logic rpt;
    } btn_evt_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Width able to hold 0..max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        int w;
        w = clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/btn_filter_ch.sv
// One debounced button channel: synchroniser, integrator, edge pulses and hold/repeat logic.
// All state advances on the shared sample tick except the synchroniser and the edge detector.
module btn_filter_ch
    import btn_pkg::*;
#(
    parameter int STABLE_CNT = STABLE_8MS,
    parameter int LONG_CNT   = LONG_1S,
    parameter int REPEAT_CNT = REPEAT_200MS
) (
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_tick,
    input  logic     i_btn,
    input  logic     i_repeat_en,
    output btn_evt_t o_evt
);

    localparam int SW = cnt_width(STABLE_CNT);
    localparam int HW = cnt_width(LONG_CNT);
    localparam int RW = cnt_width(REPEAT_CNT);

    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CNT - 1);
    localparam logic [HW-1:0] HOLD_FULL   = HW'(LONG_CNT);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(LONG_CNT - 1);
    localparam logic [RW-1:0] REP_LAST    = RW'(REPEAT_CNT - 1);

    logic [1:0]    r_sync;
    logic [SW-1:0] r_cnt;
    logic          r_level;
    logic          r_level_d;
    logic [HW-1:0] r_hold;
    logic [RW-1:0] r_rep;
    logic          r_press;
    logic          r_rel;
    logic          r_long;
    logic          r_rpt;

    logic w_s;
    logic w_differ;
    logic w_flip;
    logic w_fall;
    logic w_held_tick;
    logic w_hold_step;
    logic w_rep_step;
    logic w_rep_wrap;

    assign w_s         = r_sync[1];
    assign w_differ    = (w_s != r_level);
    assign w_flip      = i_tick & w_differ & (r_cnt == STABLE_LAST);
    assign w_fall      = w_flip & r_level;
    // The falling tick wins over hold progress so no late long/repeat escapes.
    assign w_held_tick = i_tick & r_level & ~w_fall;
    assign w_hold_step = w_held_tick & (r_hold != HOLD_FULL);
    assign w_rep_step  = w_held_tick & (r_hold == HOLD_FULL);
    assign w_rep_wrap  = w_rep_step & (r_rep == REP_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_btn};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (i_tick) begin
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (r_cnt == STABLE_LAST) begin
                r_level <= w_s;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + SW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
            r_rel     <= 1'b0;
        end else begin
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
            r_rel     <= ~r_level & r_level_d;
        end
    end

    // Counters idle at zero while released, so a new press starts fresh.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hold <= '0;
            r_rep  <= '0;
        end else if (!r_level || w_fall) begin
            r_hold <= '0;
            r_rep  <= '0;
        end else begin
            if (w_hold_step) begin
                r_hold <= r_hold + HW'(1);
            end
            if (w_rep_step) begin
                r_rep <= w_rep_wrap ? '0 : r_rep + RW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_long <= 1'b0;
            r_rpt  <= 1'b0;
        end else begin
            r_long <= w_hold_step & (r_hold == HOLD_LAST);
            r_rpt  <= w_rep_wrap & i_repeat_en;
        end
    end

    assign o_evt.level      = r_level;
    assign o_evt.press      = r_press;
    assign o_evt.rel        = r_rel;
    assign o_evt.long_press = r_long;
    assign o_evt.rpt        = r_rpt;

endmodule

// File: rtl/btn_filter_bank.sv
// Bank of N_CH independent button filters sharing one sample-tick prescaler.
// Each output bit belongs to the channel of the same index.
module btn_filter_bank
    import btn_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int SAMPLE_DIV = SAMPLE_DIV_1MS,
    parameter int STABLE_CNT = STABLE_8MS,
    parameter int LONG_CNT   = 100,
    parameter int REPEAT_CNT = 20
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N_CH-1:0] i_btn_in,
    input  logic [N_CH-1:0] i_repeat_en,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic [N_CH-1:0] o_long_press,
    output logic [N_CH-1:0] o_rpt
);

    localparam int            DW       = cnt_width(SAMPLE_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);

    logic [DW-1:0] r_div;
    logic          w_tick;

    assign w_tick = (r_div == DIV_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        btn_evt_t w_evt;

        btn_filter_ch #(
            .STABLE_CNT (STABLE_CNT),
            .LONG_CNT   (LONG_CNT),
            .REPEAT_CNT (REPEAT_CNT)
        ) u_ch (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_tick      (w_tick),
            .i_btn       (i_btn_in[g]),
            .i_repeat_en (i_repeat_en[g]),
            .o_evt       (w_evt)
        );

        assign o_level[g]      = w_evt.level;
        assign o_press[g]      = w_evt.press;
        assign o_release[g]    = w_evt.rel;
        assign o_long_press[g] = w_evt.long_press;
        assign o_rpt[g]        = w_evt.rpt;
    end

endmodule

// File: tb/tb_btn_filter_bank.sv
// Directed bench for btn_filter_bank: N_CH=2, SAMPLE_DIV=4, STABLE_CNT=3, LONG_CNT=5, REPEAT_CNT=2.
// Event times are cycle indices relative to a chosen sample-tick edge.
module tb_btn_filter_bank;

    localparam int NCH = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] btn;
    logic [NCH-1:0] rep_en;
    logic [NCH-1:0] level;
    logic [NCH-1:0] press;
    logic [NCH-1:0] rel;
    logic [NCH-1:0] lng;
    logic [NCH-1:0] rpt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pe;
    int base;

    int n_press[NCH];
    int t_press[NCH];
    int n_rel[NCH];
    int t_rel[NCH];
    int n_long[NCH];
    int t_long[NCH];
    int n_rpt[NCH];
    int t_rpt0[NCH];
    int t_rpt1[NCH];
    int n_up[NCH];
    int t_up[NCH];
    int t_dn[NCH];
    logic [NCH-1:0] lvl_q = '0;

    btn_filter_bank #(
        .N_CH       (NCH),
        .SAMPLE_DIV (4),
        .STABLE_CNT (3),
        .LONG_CNT   (5),
        .REPEAT_CNT (2)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_btn_in     (btn),
        .i_repeat_en  (rep_en),
        .o_level      (level),
        .o_press      (press),
        .o_release    (rel),
        .o_long_press (lng),
        .o_rpt        (rpt)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; sample ticks land on multiples of 4.
    always @(posedge clk or posedge rst) begin
        if (rst) pe <= 0;
        else     pe <= pe + 1;
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int c = 0; c < NCH; c++) begin
            if (press[c]) begin n_press[c]++; t_press[c] = cyc; end
            if (rel[c])   begin n_rel[c]++;   t_rel[c]   = cyc; end
            if (lng[c])   begin n_long[c]++;  t_long[c]  = cyc; end
            if (rpt[c]) begin
                if (n_rpt[c] == 0) t_rpt0[c] = cyc;
                t_rpt1[c] = cyc;
                n_rpt[c]++;
            end
            if (level[c] && !lvl_q[c]) begin n_up[c]++; t_up[c] = cyc; end
            if (!level[c] && lvl_q[c]) t_dn[c] = cyc;
        end
        lvl_q = level;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic align();
        do cycles(1); while (pe % 4 != 0);
        base = cyc + 1;
    endtask

    task automatic clr();
        for (int c = 0; c < NCH; c++) begin
            n_press[c] = 0; t_press[c] = 0;
            n_rel[c]   = 0; t_rel[c]   = 0;
            n_long[c]  = 0; t_long[c]  = 0;
            n_rpt[c]   = 0; t_rpt0[c]  = 0; t_rpt1[c] = 0;
            n_up[c]    = 0; t_up[c]    = 0; t_dn[c]   = 0;
        end
    endtask

    function automatic int outs();
        return int'({level, press, rel, lng, rpt});
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst    = 1'b1;
        btn    = '0;
        rep_en = '0;
        clr();
        #1;
        check("reset outs t0", outs(), 0);
        cycles(3);
        check("reset outs held", outs(), 0);
        rst = 1'b0;

        // Clean press, long press and auto-repeat, then release.
        clr();
        align();
        btn    = 2'b01;
        rep_en = 2'b01;
        cycles(50);
        btn = 2'b00;
        cycles(20);
        check("A level0 rise", t_up[0], base + 12);
        check("A press0 n", n_press[0], 1);
        check("A press0 t", t_press[0], base + 13);
        check("A long0 n", n_long[0], 1);
        check("A long0 t", t_long[0], base + 32);
        check("A rpt0 n", n_rpt[0], 3);
        check("A rpt0 first", t_rpt0[0], base + 40);
        check("A rpt0 last", t_rpt1[0], base + 56);
        check("A level0 fall", t_dn[0], base + 64);
        check("A rel0 n", n_rel[0], 1);
        check("A rel0 t", t_rel[0], base + 65);
        check("A ch1 quiet", n_up[1] + n_press[1] + n_rel[1] + n_long[1] + n_rpt[1], 0);

        // Bounce: 2 ticks high, 1 low, 2 high, then low.
        clr();
        align();
        btn = 2'b01;
        cycles(8);
        btn = 2'b00;
        cycles(4);
        btn = 2'b01;
        cycles(8);
        btn = 2'b00;
        cycles(20);
        check("B level0 rises", n_up[0], 0);
        check("B press0 n", n_press[0], 0);
        check("B rel0 n", n_rel[0], 0);
        check("B outs", outs(), 0);

        // Release before LONG_CNT; the long pulse due on the falling tick is dropped.
        clr();
        align();
        btn    = 2'b01;
        rep_en = 2'b00;
        cycles(20);
        btn = 2'b00;
        cycles(16);
        check("C press0 n", n_press[0], 1);
        check("C level0 fall", t_dn[0], base + 32);
        check("C rel0 t", t_rel[0], base + 33);
        check("C long0 n", n_long[0], 0);

        // Fresh hold restarts from zero; repeat disabled gives no rpt.
        clr();
        align();
        btn = 2'b01;
        cycles(60);
        check("D level0 rise", t_up[0], base + 12);
        check("D long0 n", n_long[0], 1);
        check("D long0 t", t_long[0], base + 32);
        check("D rpt0 n", n_rpt[0], 0);
        btn = 2'b00;
        cycles(20);
        check("D level0 end", int'(level), 0);

        // Reset mid-hold with the button kept high.
        clr();
        align();
        rep_en = 2'b01;
        btn    = 2'b01;
        cycles(24);
        check("E1 level0 pre", int'(level[0]), 1);
        rst = 1'b1;
        #1;
        check("E1 outs in reset", outs(), 0);
        cycles(3);
        clr();
        rst  = 1'b0;
        base = cyc + 1;
        cycles(16);
        check("E1 level0 rise", t_up[0], base + 12);
        check("E1 press0 n", n_press[0], 1);
        check("E1 press0 t", t_press[0], base + 13);
        check("E1 other pulses", n_rel[0] + n_long[0] + n_rpt[0], 0);

        // Reset while the falling integrator count sits at 2.
        align();
        btn = 2'b00;
        cycles(9);
        check("E2 level0 pre", int'(level[0]), 1);
        rst = 1'b1;
        #1;
        check("E2 outs in reset", outs(), 0);
        cycles(2);
        clr();
        rst = 1'b0;
        cycles(30);
        check("E2 pulses after rst", n_press[0] + n_rel[0] + n_up[0], 0);

        // Both channels together.
        clr();
        align();
        rep_en = 2'b00;
        btn    = 2'b11;
        cycles(40);
        check("F press0 t", t_press[0], base + 13);
        check("F press1 t", t_press[1], base + 13);
        check("F press n", n_press[0] + n_press[1], 2);
        check("F long0 t", t_long[0], base + 32);
        check("F long1 t", t_long[1], base + 32);
        btn = 2'b00;
        cycles(24);
        check("F rel0 t", t_rel[0], base + 53);
        check("F rel1 t", t_rel[1], base + 53);
        check("F level end", int'(level), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_filter_bank.md
Name: btn_filter_bank

Overview:
- Parametrised multi-channel successor to the single-button filter used for btnC/btnU.
- Debounces N_CH asynchronous push-buttons with one shared sample prescaler.
- Per channel it outputs a clean level plus one-cycle press and release pulses, a long-press pulse, and optional auto-repeat pulses.
- Sits between the raw board buttons and the top-level control/display logic (counters, 7-seg, LEDs).

Parameters:
- N_CH, 4: number of button channels (1..16).
- SAMPLE_DIV, 100000: clk cycles per sample tick (>=1; 1 = tick every cycle).
- STABLE_CNT, 8: consecutive differing samples needed to change level (>=1).
- LONG_CNT, 100: sample ticks of held level before the long pulse (>=1).
- REPEAT_CNT, 20: sample ticks between auto-repeat pulses after the long pulse (>=1).

Ports:
- clk, in, 1: system clock; all logic is on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- btn_in, in, N_CH: raw asynchronous button inputs, active-high.
- repeat_en, in, N_CH: per-channel auto-repeat enable, sampled each tick.
- level, out, N_CH: debounced registered button state.
- press, out, N_CH: one-cycle pulse on level 0->1.
- release, out, N_CH: one-cycle pulse on level 1->0.
- long_press, out, N_CH: one-cycle pulse when held for LONG_CNT ticks.
- rpt, out, N_CH: one-cycle auto-repeat pulse.

Behaviour:
- Reset: while rst=1, all registers and outputs go to 0 immediately (asynchronous). This covers synchronisers, prescaler, counters, level, press, release, long_press and rpt. No pulses are generated on the rst falling edge.
- Prescaler: a shared counter runs 0..SAMPLE_DIV-1. tick=1 for one cycle when the counter equals SAMPLE_DIV-1, then it wraps to 0.
- Synchroniser: two flip-flops per channel. s = second stage.
- Integrator, per channel (cnt width clog2(STABLE_CNT+1)). On a tick:
  - if s==level: cnt<=0.
  - else if cnt==STABLE_CNT-1: level<=s and cnt<=0.
  - else: cnt<=cnt+1.
  - Result: level changes only after STABLE_CNT consecutive differing ticks. Any agreeing sample clears the count.
- Latency: from a stable input edge to level, 2 cycles + (STABLE_CNT-1)*SAMPLE_DIV + up to SAMPLE_DIV + 1 cycles.
- Edge pulses: press/release are registered and asserted in the cycle after level changes, for exactly one cycle. Each level change yields exactly one pulse.
- Hold logic, per channel (hold_cnt saturating, rep_cnt):
  - On level rise: hold_cnt<=0, rep_cnt<=0.
  - On each tick while level=1 and hold_cnt<LONG_CNT: hold_cnt++. When it reaches LONG_CNT, long_press pulses for one cycle.
  - On each tick while level=1 and hold_cnt==LONG_CNT: rep_cnt++. When it reaches REPEAT_CNT, rep_cnt<=0 and rpt pulses only if repeat_en=1 on that tick.
  - rpt never pulses before long_press.
  - Level falling clears hold_cnt and rep_cnt in the same cycle; a pending long or repeat pulse is not issued.
  - repeat_en deasserted mid-hold suppresses rpt without resetting rep_cnt.
- Channels are fully independent. Simultaneous ticks and edges on several channels produce simultaneous pulses.
- Glitch shorter than STABLE_CNT ticks: no change on any output.
- Input held high through reset release: press is issued after the normal debounce latency.

Decomposition:
- Shared header/package btn_pkg holds:
  - default timing constants for the 100 MHz board (SAMPLE_DIV_1MS, STABLE_8MS, LONG_1S, REPEAT_200MS);
  - a clog2 constant function.
- Sub-module btn_filter_ch: one channel (synchroniser, integrator, edge and hold logic) with a tick input. It is instantiated N_CH times by a generate loop.
- The prescaler stays in btn_filter_bank.

Test Plan:
Bench setup: N_CH=2, SAMPLE_DIV=4, STABLE_CNT=3, LONG_CNT=5, REPEAT_CNT=2.
1. Clean press: btn_in[0] 0->1 and held.
   -> level[0]=1 within 2+12+5 cycles.
   -> press[0] high exactly 1 cycle.
   -> channel 1 outputs stay 0.
2. Bounce: btn_in[0] high for 2 ticks, low 1 tick, high 2 ticks, then low.
   -> level[0] stays 0; no press/release pulses.
3. Long hold with repeat_en[0]=1: hold btn_in[0] high for 12 ticks after level rise.
   -> long_press at tick 5.
   -> rpt at ticks 7, 9, 11.
   -> repeat with repeat_en=0: long_press only, no rpt.
4. Release after 3 held ticks.
   -> release[0] one cycle after level falls; no long_press.
   -> next press restarts the hold count from 0.
5. rst asserted mid-integration (cnt=2) and mid-hold.
   -> all outputs 0 within the same cycle; no pulses after release of rst.
   -> if the input is still high, press follows the normal latency.
6. Both channels pressed in the same cycle.
   -> press[1:0]=2'b11 in the same cycle; long_press[1:0]=2'b11 together.
